// File: rtl/armleocpu_regread.sv
// armleocpu_regread -- register-read stage between fetch and execute.
//
// Accepts one instruction per cycle from fetch (f2d_*), issues the rs1/rs2
// reads to the regfile in the accept cycle and presents instruction, PC and
// operands to execute (d2e_*) one cycle later. Held operands are kept
// coherent with writeback traffic (rd_*).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   f2d_valid/ready/instr/pc   fetch handshake and payload
//   kill                       flush held and incoming instruction
//   rs1/rs2_read/addr/rdata    regfile read ports (rdata valid cycle after read,
//                              held by the regfile while read=0)
//   rd_write/addr/wdata        writeback snoop (same net as the regfile)
//   d2e_valid/ready            execute handshake
//   d2e_instr/pc/rs1_data/rs2_data  payload to execute
//
// Configuration:
//   ARMLEOCPU_REGREAD_BYPASS_EN defined   -> writeback hits are forwarded
//                                            into per-operand bypass regs.
//   ARMLEOCPU_REGREAD_BYPASS_EN undefined -> writeback hits send the stage to
//                                            REREAD, re-issuing the reads.
module armleocpu_regread (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f2d_valid,
  output logic        f2d_ready,
  input  logic [31:0] f2d_instr,
  input  logic [31:0] f2d_pc,
  input  logic        kill,
  output logic        rs1_read,
  output logic        rs2_read,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_rdata,
  input  logic [31:0] rs2_rdata,
  input  logic        rd_write,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_wdata,
  output logic        d2e_valid,
  input  logic        d2e_ready,
  output logic [31:0] d2e_instr,
  output logic [31:0] d2e_pc,
  output logic [31:0] d2e_rs1_data,
  output logic [31:0] d2e_rs2_data
);

  typedef enum logic [1:0] {EMPTY, FULL, REREAD} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic [4:0] rs1_q, rs2_q;
  logic       match1, match2;
  logic       hazard;

  assign rs1_q = d2e_instr[19:15];
  assign rs2_q = d2e_instr[24:20];

  // rst_n gating keeps fetch from seeing a handshake that the held-in-reset
  // flops would silently drop.
  assign f2d_ready = rst_n && !kill && (state != REREAD) &&
                     ((state == EMPTY) || d2e_ready);
  assign accept    = f2d_valid && f2d_ready;

  // Outside the accept cycle the addresses point at the held instruction,
  // so REREAD re-issues exactly the same registers.
  assign rs1_addr = accept ? f2d_instr[19:15] : rs1_q;
  assign rs2_addr = accept ? f2d_instr[24:20] : rs2_q;
  assign rs1_read = rst_n && (accept || (state == REREAD));
  assign rs2_read = rs1_read;

  // A write landing on an address being read (or held) this cycle. The
  // regfile returns the pre-write value for a same-cycle read/write, so the
  // accept cycle needs this just as much as the held cycles do.
  assign match1 = rd_write && (rd_addr != 5'd0) && (rd_addr == rs1_addr);
  assign match2 = rd_write && (rd_addr != 5'd0) && (rd_addr == rs2_addr);

  assign d2e_valid = (state == FULL);

`ifdef ARMLEOCPU_REGREAD_BYPASS_EN
  logic [31:0] byp1, byp2;
  logic        sel1, sel2;

  assign hazard = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp1 <= '0;
      byp2 <= '0;
      sel1 <= 1'b0;
      sel2 <= 1'b0;
    end else if (kill) begin
      sel1 <= 1'b0;
      sel2 <= 1'b0;
    end else if (accept || (state == FULL)) begin
      // A new instruction starts from regfile data unless the write that is
      // racing its read must be captured here.
      if (match1) begin
        byp1 <= rd_wdata;
        sel1 <= 1'b1;
      end else if (accept) begin
        sel1 <= 1'b0;
      end
      if (match2) begin
        byp2 <= rd_wdata;
        sel2 <= 1'b1;
      end else if (accept) begin
        sel2 <= 1'b0;
      end
    end
  end

  assign d2e_rs1_data = (rs1_q == 5'd0) ? '0 : (sel1 ? byp1 : rs1_rdata);
  assign d2e_rs2_data = (rs2_q == 5'd0) ? '0 : (sel2 ? byp2 : rs2_rdata);
`else
  logic unused_wdata;

  assign unused_wdata = ^rd_wdata;
  assign hazard       = match1 || match2;

  assign d2e_rs1_data = (rs1_q == 5'd0) ? '0 : rs1_rdata;
  assign d2e_rs2_data = (rs2_q == 5'd0) ? '0 : rs2_rdata;
`endif

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = hazard ? REREAD : FULL;
    end else begin
      case (state)
        FULL:    if (d2e_ready) state_nxt = EMPTY;
                 else if (hazard) state_nxt = REREAD;
        REREAD:  state_nxt = hazard ? REREAD : FULL;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d2e_instr <= '0;
      d2e_pc    <= '0;
    end else if (accept) begin
      d2e_instr <= f2d_instr;
      d2e_pc    <= f2d_pc;
    end
  end

endmodule

// File: tb/tb_armleocpu_regread.sv
// Self-checking bench for armleocpu_regread. A simple regfile model answers
// the read ports; a scoreboard holds the accepted-but-not-consumed
// instructions and, whenever d2e_valid is high, requires the payload to be
// the oldest one and the operands to equal the committed register contents.
// Directed sequences add literal expectations for timing and boundary cases.
module tb_armleocpu_regread;

  logic        clk;
  logic        rst_n;
  logic        f2d_valid, f2d_ready;
  logic [31:0] f2d_instr, f2d_pc;
  logic        kill;
  logic        rs1_read, rs2_read;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_rdata, rs2_rdata;
  logic        rd_write;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        d2e_valid, d2e_ready;
  logic [31:0] d2e_instr, d2e_pc, d2e_rs1_data, d2e_rs2_data;

  int checks = 0;
  int errors = 0;

  armleocpu_regread dut (
    .clk(clk), .rst_n(rst_n),
    .f2d_valid(f2d_valid), .f2d_ready(f2d_ready),
    .f2d_instr(f2d_instr), .f2d_pc(f2d_pc),
    .kill(kill),
    .rs1_read(rs1_read), .rs2_read(rs2_read),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .d2e_valid(d2e_valid), .d2e_ready(d2e_ready),
    .d2e_instr(d2e_instr), .d2e_pc(d2e_pc),
    .d2e_rs1_data(d2e_rs1_data), .d2e_rs2_data(d2e_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile: registered read of the pre-write value. x0 is deliberately not
  // hardwired so the stage's own x0 forcing is what keeps operands at zero.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rs1_read) rs1_rdata <= regs[rs1_addr];
    if (rs2_read) rs2_rdata <= regs[rs2_addr];
    if (rd_write) regs[rd_addr] <= rd_wdata;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } pkt_t;
  pkt_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : regs[a];
  endfunction

  // add x3, rs1, rs2
  function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'd0, 5'd3, 7'h33};
  endfunction

  // Scoreboard compare + model update, once per cycle away from the edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk1("sb_reset_valid", d2e_valid, 1'b0);
    end else begin
      if (d2e_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got d2e_valid=1 expected no outstanding instruction");
        end else begin
          chk("sb_instr", d2e_instr, q[0].instr);
          chk("sb_pc", d2e_pc, q[0].pc);
          chk("sb_rs1", d2e_rs1_data, opnd(q[0].instr[19:15]));
          chk("sb_rs2", d2e_rs2_data, opnd(q[0].instr[24:20]));
        end
      end
      if (d2e_valid && d2e_ready && q.size() > 0) void'(q.pop_front());
      if (kill) q.delete();
      if (f2d_valid && f2d_ready) q.push_back('{f2d_instr, f2d_pc});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    f2d_valid = 1'b0;
    kill      = 1'b0;
    rd_write  = 1'b0;
    d2e_ready = 1'b1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rd_write = 1'b1;
    rd_addr  = a;
    rd_wdata = d;
  endtask

  // Four add x3,x1,x2 back to back with execute always ready.
  task automatic b2b(input logic [31:0] base, input logic [31:0] e2);
    for (int i = 0; i < 6; i++) begin
      f2d_valid = (i < 4);
      f2d_instr = mk(5'd1, 5'd2);
      f2d_pc    = base + 4 * i;
      smp();
      if (i == 0) begin
        chk1("b2b_ready", f2d_ready, 1'b1);
        chk1("b2b_rs1_read", rs1_read, 1'b1);
        chk("b2b_rs1_addr", 32'(rs1_addr), 32'd1);
        chk("b2b_rs2_addr", 32'(rs2_addr), 32'd2);
      end
      if (i >= 1 && i <= 4) begin
        chk1("b2b_valid", d2e_valid, 1'b1);
        chk("b2b_rs1", d2e_rs1_data, 32'd5);
        chk("b2b_rs2", d2e_rs2_data, e2);
        chk("b2b_pc", d2e_pc, base + 4 * (i - 1));
      end
      if (i == 5) chk1("b2b_drain", d2e_valid, 1'b0);
      nxt();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    f2d_valid = 1'b0; f2d_instr = '0; f2d_pc = '0; kill = 1'b0;
    rd_write = 1'b0; rd_addr = '0; rd_wdata = '0; d2e_ready = 1'b1;
    #1 rst_n = 1'b0;
    smp();
    chk1("reset_valid", d2e_valid, 1'b0);
    chk("reset_pc", d2e_pc, 32'h0);
    chk("reset_instr", d2e_instr, 32'h0);
    chk1("reset_rs1_read", rs1_read, 1'b0);
    chk1("reset_rs2_read", rs2_read, 1'b0);
    chk("reset_rs1_data", d2e_rs1_data, 32'h0);
    #2 rst_n = 1'b1;

    // Preload through the writeback port while the stage is empty.
    regs[0] = 32'h0;
    nxt(); wr(5'd1, 32'd5);
    nxt(); wr(5'd2, 32'd7);
    nxt(); wr(5'd4, 32'h100);
    nxt(); idle();

    b2b(32'h100, 32'd7);

    // Same-cycle hazard: accept rs1=x4 while x4 is being written.
    idle(); f2d_valid = 1'b1; f2d_instr = mk(5'd4, 5'd2); f2d_pc = 32'h200;
    wr(5'd4, 32'hDEADBEEF);
    smp(); chk("haz_rs1_addr", 32'(rs1_addr), 32'd4);
    nxt(); idle();
    smp();
`ifdef ARMLEOCPU_REGREAD_BYPASS_EN
    chk1("haz_valid", d2e_valid, 1'b1);
    chk("haz_rs1", d2e_rs1_data, 32'hDEADBEEF);
`else
    chk1("haz_bubble", d2e_valid, 1'b0);
    chk1("haz_reread", rs1_read, 1'b1);
    chk1("haz_reread_ready", f2d_ready, 1'b0);
`endif
    nxt(); smp();
`ifdef ARMLEOCPU_REGREAD_BYPASS_EN
    chk1("haz_done", d2e_valid, 1'b0);
`else
    chk1("haz_valid", d2e_valid, 1'b1);
    chk("haz_rs1", d2e_rs1_data, 32'hDEADBEEF);
    chk("haz_rs2", d2e_rs2_data, 32'd7);
`endif
    nxt();

    // Stall coherence: x2 written while execute stalls.
    idle(); f2d_valid = 1'b1; f2d_instr = mk(5'd1, 5'd2); f2d_pc = 32'h300; d2e_ready = 1'b0;
    nxt(); f2d_valid = 1'b0;
    smp(); chk1("stall_v1", d2e_valid, 1'b1); chk("stall_rs2_1", d2e_rs2_data, 32'd7);
    nxt(); wr(5'd2, 32'h1234);
    smp(); chk("stall_rs2_2", d2e_rs2_data, 32'd7);
    nxt(); rd_write = 1'b0;
    smp();
`ifdef ARMLEOCPU_REGREAD_BYPASS_EN
    chk1("stall_fwd_valid", d2e_valid, 1'b1);
    chk("stall_fwd_rs2", d2e_rs2_data, 32'h1234);
`else
    chk1("stall_bubble", d2e_valid, 1'b0);
`endif
    chk("stall_instr", d2e_instr, mk(5'd1, 5'd2));
    nxt(); d2e_ready = 1'b1;
    smp();
    chk1("stall_valid", d2e_valid, 1'b1);
    chk("stall_rs2", d2e_rs2_data, 32'h1234);
    chk("stall_pc", d2e_pc, 32'h300);
    nxt(); idle();
    smp(); chk1("stall_drain", d2e_valid, 1'b0);
    nxt();

    // x0 source while writeback targets x0.
    idle(); f2d_valid = 1'b1; f2d_instr = mk(5'd0, 5'd1); f2d_pc = 32'h400;
    wr(5'd0, 32'hFFFFFFFF);
    nxt(); idle();
    smp();
    chk1("x0_valid", d2e_valid, 1'b1);
    chk("x0_rs1", d2e_rs1_data, 32'h0);
    chk("x0_rs2", d2e_rs2_data, 32'd5);
    nxt();

    // Kill with a held instruction and a new one offered.
    idle(); f2d_valid = 1'b1; f2d_instr = mk(5'd1, 5'd2); f2d_pc = 32'h500; d2e_ready = 1'b0;
    nxt(); kill = 1'b1; f2d_pc = 32'h504;
    smp();
    chk1("kill_held_valid", d2e_valid, 1'b1);
    chk1("kill_ready", f2d_ready, 1'b0);
    nxt(); idle();
    smp(); chk1("kill_flushed", d2e_valid, 1'b0);
    nxt();

    // Reset in the middle of a stall.
    idle(); f2d_valid = 1'b1; f2d_instr = mk(5'd1, 5'd2); f2d_pc = 32'h600; d2e_ready = 1'b0;
    nxt(); f2d_pc = 32'h604;
    smp();
    chk1("rst_pre_valid", d2e_valid, 1'b1);
    chk("rst_pre_pc", d2e_pc, 32'h600);
    #2 rst_n = 1'b0;
    #1;
    chk1("rst_async_valid", d2e_valid, 1'b0);
    chk("rst_async_pc", d2e_pc, 32'h0);
    chk1("rst_no_read", rs1_read, 1'b0);
    nxt(); smp();
    chk1("rst_hold_valid", d2e_valid, 1'b0);
    chk1("rst_hold_no_read", rs1_read, 1'b0);
    idle();
    #2 rst_n = 1'b1;
    nxt();
    b2b(32'h700, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
